// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple counter and its clk-domain sampler.
// Holds the FSM state type, default widths, and a counter-width helper.
package ripple_pkg;

    localparam int RIPPLE_CNT_W         = 4;
    localparam int RIPPLE_STABLE_CYCLES = 2;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } ripple_state_t;

    // Bits needed to hold a saturating count of 0..cycles
    function automatic int stable_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ripple_sync_filter.sv
// Two-flop synchroniser for the asynchronous ripple value, followed by a
// stability counter that flags the synchronised value as settled.
module ripple_sync_filter
    import ripple_pkg::*;
#(
    parameter int CNT_W         = RIPPLE_CNT_W,
    parameter int STABLE_CYCLES = RIPPLE_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] ripple_q,
    output logic             settled,
    output logic [CNT_W-1:0] value
);

    localparam int              SC_W   = stable_cnt_width(STABLE_CYCLES);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);

    logic [CNT_W-1:0] s1_reg;
    logic [CNT_W-1:0] s2_reg;
    logic [CNT_W-1:0] bit_changed;
    logic [SC_W-1:0]  stable_cnt_reg;
    logic [SC_W-1:0]  stable_cnt_next;

    // s1 is the value s2 is about to load, so any differing bit means a new value
    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_cmp
            assign bit_changed[gi] = s1_reg[gi] ^ s2_reg[gi];
        end
    endgenerate

    always_comb begin
        stable_cnt_next = stable_cnt_reg;
        if (|bit_changed) begin
            stable_cnt_next = SC_W'(1);
        end else if (stable_cnt_reg != SC_MAX) begin
            stable_cnt_next = stable_cnt_reg + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg         <= '0;
            s2_reg         <= '0;
            stable_cnt_reg <= '0;
        end else begin
            s1_reg         <= ripple_q;
            s2_reg         <= s1_reg;
            stable_cnt_reg <= clear ? '0 : stable_cnt_next;
        end
    end

    assign settled = (stable_cnt_reg == SC_MAX);
    assign value   = s2_reg;

endmodule

// File: rtl/ripple_sampler.sv
// Turns settled ripple counter values into modulo step deltas, accumulates a
// wrapping running total and presents merged deltas over valid/ready.
module ripple_sampler
    import ripple_pkg::*;
#(
    parameter int CNT_W         = RIPPLE_CNT_W,
    parameter int ACC_W         = 16,
    parameter int STABLE_CYCLES = RIPPLE_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] ripple_q,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_delta,
    output logic [ACC_W-1:0] out_total,
    output logic             overflow
);

    logic             settled;
    logic [CNT_W-1:0] value;

    ripple_state_t    state_reg;
    logic [CNT_W-1:0] last_reg;
    logic             valid_reg;
    logic [ACC_W-1:0] delta_reg;
    logic [ACC_W-1:0] total_reg;
    logic             overflow_reg;

    logic [CNT_W-1:0] step_raw;
    logic [ACC_W-1:0] step_ext;
    logic [ACC_W:0]   total_sum;
    logic [ACC_W:0]   merge_sum;
    logic [ACC_W-1:0] merged_delta;
    logic [ACC_W-1:0] delta_next;
    logic             event_fire;

    ripple_sync_filter #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .ripple_q (ripple_q),
        .settled  (settled),
        .value    (value)
    );

    // Subtraction wraps at CNT_W bits, which is exactly the forward step count
    assign step_raw     = value - last_reg;
    assign step_ext     = ACC_W'(step_raw);
    assign total_sum    = {1'b0, total_reg} + {1'b0, step_ext};
    assign merge_sum    = {1'b0, delta_reg} + {1'b0, step_ext};
    assign merged_delta = merge_sum[ACC_W] ? '1 : merge_sum[ACC_W-1:0];
    assign event_fire   = (state_reg == TRACK) && settled && (value != last_reg);

    // A held, unaccepted delta absorbs the new step; otherwise the step replaces it
    assign delta_next   = (valid_reg && !out_ready) ? merged_delta : step_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= PRIME;
            last_reg     <= '0;
            valid_reg    <= 1'b0;
            delta_reg    <= '0;
            total_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            state_reg    <= PRIME;
            last_reg     <= '0;
            valid_reg    <= 1'b0;
            delta_reg    <= '0;
            total_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                PRIME: begin
                    if (settled) begin
                        last_reg  <= value;
                        state_reg <= TRACK;
                    end
                end
                TRACK: begin
                    if (event_fire) begin
                        last_reg     <= value;
                        total_reg    <= total_sum[ACC_W-1:0];
                        overflow_reg <= overflow_reg | total_sum[ACC_W];
                    end
                end
            endcase

            if (event_fire) begin
                valid_reg <= 1'b1;
                delta_reg <= delta_next;
            end else if (valid_reg && out_ready) begin
                valid_reg <= 1'b0;
                delta_reg <= '0;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_delta = delta_reg;
    assign out_total = total_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ripple_sampler.sv
// Directed and randomized checks of ripple_sampler against a step-level model
// of accepted counter values, running total and pending delta.
`timescale 1ns/1ps
module tb_ripple_sampler;
    import ripple_pkg::*;

    localparam int CNT_W = 4;
    localparam int ACC_W = 16;
    localparam int SC    = 2;
    localparam int MAXV  = 65535;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             clear     = 1'b0;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] ripple_q  = '0;
    logic             out_valid;
    logic [ACC_W-1:0] out_delta;
    logic [ACC_W-1:0] out_total;
    logic             overflow;

    ripple_sampler #(
        .CNT_W         (CNT_W),
        .ACC_W         (ACC_W),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ripple_q  (ripple_q),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_delta (out_delta),
        .out_total (out_total),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted value, wrapping total, pending delta
    int m_last    = 0;
    int m_total   = 0;
    int m_pending = 0;
    bit m_valid   = 1'b0;
    bit m_ovf     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_last = 0; m_total = 0; m_pending = 0; m_valid = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"},    32'(out_valid), 32'(m_valid));
        chk({tag, ".delta"},    32'(out_delta), 32'(m_pending));
        chk({tag, ".total"},    32'(out_total), 32'(m_total));
        chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    // Hold v long enough to be accepted; the model then applies the step rules
    task automatic prime(input int v);
        ripple_q = CNT_W'(v);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("prime.valid", 32'(out_valid), 32'(0));
        end
        m_last = v;
        chk("prime.state", 32'(dut.state_reg), 32'(TRACK));
        chk("prime.last",  32'(dut.last_reg),  32'(v));
        $display("prime v=%0d", v);
    endtask

    // Optional one-cycle glitch g before v; rdy is applied on the accepting edge only
    task automatic step(input int v, input int g, input bit rdy);
        int d;
        if (g >= 0) begin
            ripple_q = CNT_W'(g);
            tick(1);
        end
        ripple_q  = CNT_W'(v);
        out_ready = 1'b0;
        tick(3);
        check_outputs("pre");
        out_ready = rdy;
        tick(1);
        out_ready = 1'b0;
        d = (v - m_last) & 15;
        if (d != 0) begin
            m_total = m_total + d;
            if (m_total > MAXV) begin
                m_total = m_total - (MAXV + 1);
                m_ovf   = 1'b1;
            end
            if (m_valid && !rdy) begin
                m_pending = (m_pending + d > MAXV) ? MAXV : m_pending + d;
            end else begin
                m_pending = d;
            end
            m_valid = 1'b1;
            m_last  = v;
        end else if (m_valid && rdy) begin
            m_valid   = 1'b0;
            m_pending = 0;
        end
        check_outputs("step");
        $display("step v=%0d glitch=%0d ready=%0b d=%0d valid=%0b delta=%0d total=%0d ovf=%0b",
                 v, g, rdy, d, out_valid, out_delta, out_total, overflow);
    endtask

    task automatic xfer();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_pending = 0;
        check_outputs("xfer");
        $display("xfer valid=%0b delta=%0d total=%0d", out_valid, out_delta, out_total);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_reset();
        check_outputs("clear");
        chk("clear.state", 32'(dut.state_reg), 32'(PRIME));
        $display("clear valid=%0b delta=%0d total=%0d ovf=%0b", out_valid, out_delta, out_total, overflow);
    endtask

    function automatic int pick_glitch(input int v, input int cur);
        int g;
        g = v;
        while (g == v || g == cur) g = int'($urandom_range(0, 15));
        return g;
    endfunction

    initial begin
        int d, v, g;

        // Reset state, then prime at 5 with no event
        ripple_q = 4'd5;
        tick(2);
        check_outputs("reset");
        reset = 1'b1;
        prime(5);

        // 5 -> 9: event appears exactly on the fourth edge
        step(9, -1, 1'b0);
        chk("t2.delta", 32'(out_delta), 32'(4));
        chk("t2.total", 32'(out_total), 32'(4));
        xfer();

        // 14 -> 2 wraps modulo 16
        do_clear();
        prime(14);
        step(2, -1, 1'b0);
        chk("t3.delta", 32'(out_delta), 32'(4));
        xfer();

        // One-cycle glitch to 7 between 3 and 4 is never accepted
        step(3, -1, 1'b0);
        xfer();
        step(4, 7, 1'b0);
        chk("t4.delta", 32'(out_delta), 32'(1));
        tick(4);
        check_outputs("t4.hold");
        xfer();

        // Merge while stalled, then transfer and new event on the same edge
        step(3, -1, 1'b0);
        xfer();
        step(5, -1, 1'b0);
        step(6, -1, 1'b0);
        chk("t5.merged", 32'(out_delta), 32'(3));
        step(8, -1, 1'b1);
        chk("t5.next", 32'(out_delta), 32'(2));
        xfer();

        // Randomized steps up to the total wrap point
        do_clear();
        prime(int'(ripple_q));
        while (m_total < MAXV - 15) begin
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(10, 15));
            v = (m_last + d) & 15;
            g = ($urandom_range(0, 3) == 0) ? pick_glitch(v, m_last) : -1;
            step(v, g, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) xfer();
        end
        step((m_last + (MAXV - m_total)) & 15, -1, 1'b0);
        chk("t6.full", 32'(out_total), 32'(MAXV));
        chk("t6.noovf", 32'(overflow), 32'(0));
        step((m_last + 1) & 15, -1, 1'b0);
        chk("t6.wrap", 32'(out_total), 32'(0));
        chk("t6.ovf", 32'(overflow), 32'(1));
        do_clear();

        // Stalled consumer: pending delta saturates when the total wraps
        prime(int'(ripple_q));
        while (m_total < MAXV) step((m_last + 15) & 15, -1, 1'b0);
        chk("sat.pending", 32'(out_delta), 32'(MAXV));
        step((m_last + 1) & 15, -1, 1'b0);
        chk("sat.delta", 32'(out_delta), 32'(MAXV));
        chk("sat.total", 32'(out_total), 32'(0));
        chk("sat.ovf", 32'(overflow), 32'(1));

        // Asynchronous reset mid-stream clears outputs without a clock edge
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("areset");
        tick(2);
        reset = 1'b1;
        prime(int'(ripple_q));
        step((m_last + 3) & 15, -1, 1'b0);
        chk("rearm.delta", 32'(out_delta), 32'(3));
        chk("rearm.total", 32'(out_total), 32'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ripple_sampler.md
# ripple_sampler

- Downstream consumer of the 4-bit asynchronous ripple counter.
- Samples the counter's `q` into the `clk` domain and rejects mid-ripple transient values with a stability filter.
- Converts each settled change into a modulo-2^CNT_W step delta and accumulates it into a wide running total.
- Hands results to synchronous logic through a valid/ready interface with a sticky overflow flag.

## Interface
- `CNT_W`, default 4: width of the ripple counter value.
- `ACC_W`, default 16: width of the running total and the pending delta; must be ≥ CNT_W+1.
- `STABLE_CYCLES`, default 2: consecutive equal samples required to accept a value; must be ≥ 1.

- `clk` in, 1: single clock. The whole block is synchronous to it.
- `reset` in, 1: asynchronous, active-low reset.
- `ripple_q` in, CNT_W: raw ripple counter output, asynchronous to `clk`.
- `clear` in, 1: synchronous clear; returns the block to the just-reset condition.
- `out_valid` out, 1: an event is pending.
- `out_ready` in, 1: consumer accepts the pending event.
- `out_delta` out, ACC_W: sum of steps since the last completed transfer.
- `out_total` out, ACC_W: running total of all steps since reset or clear, wrapping.
- `overflow` out, 1: sticky; set when `out_total` wraps.

## Operation
- **Synchroniser:** two flops, `s1` then `s2`. Multi-bit skew is tolerated because the filter follows.
- **Stability filter:**
  - `stable_cnt` counts consecutive edges on which `s2` holds the same value. The edge that loads a new value counts as 1.
  - The count saturates at STABLE_CYCLES.
  - `s2` is "settled" while `stable_cnt` == STABLE_CYCLES.
- **FSM, state PRIME:**
  - The first settled value loads `last`; no event is produced.
  - Go to TRACK.
- **FSM, state TRACK:**
  - When a settled value v ≠ `last` appears: d = (v − `last`) mod 2^CNT_W, zero-extended to ACC_W.
  - `out_total` += d, mod 2^ACC_W. If the addition carries out, set `overflow`.
  - `last` ← v.
  - Event merged into the output register, below.
  - A settled value equal to `last` does nothing.
- **Output register, new event d:**
  - If `out_valid`=0: `out_delta` ← d, `out_valid` ← 1.
  - If `out_valid`=1 and `out_ready`=0: `out_delta` ← `out_delta` + d, saturating at 2^ACC_W−1. `out_valid` stays 1.
  - If `out_valid`=1 and `out_ready`=1: `out_delta` ← d, `out_valid` stays 1. No step is lost.
- **Output register, no event:** a transfer (`out_valid`&&`out_ready`) drops `out_valid` and zeroes `out_delta`.
- **Constraints:**
  - `out_delta`, `out_valid` and `out_total` are stable while `out_valid`=1 and `out_ready`=0, except when merging a new event.
  - A source advancing ≥ 2^CNT_W steps between accepted values aliases. This is a documented system constraint, not detected.
- **`clear`:**
  - Same values as reset: state PRIME, `out_valid`=0, `out_delta`=0, `out_total`=0, `overflow`=0, `stable_cnt`=0.
  - `s1`/`s2` keep sampling.
  - `clear` wins over any event or transfer in the same cycle.
- **Reset values:** `s1`=`s2`=`last`=0, `stable_cnt`=0, state PRIME, `out_valid`=0, `out_delta`=0, `out_total`=0, `overflow`=0.

## Timing
- Latency: with `ripple_q` steady at X from before edge 1, `s2`=X after edge 2 and X is settled after edge 1+STABLE_CYCLES. The event is registered and `out_valid` is high after edge 2+STABLE_CYCLES (edge 4 at the default).
- A value held for fewer than STABLE_CYCLES edges in `s2` is never accepted.
- Throughput: one event per cycle at most.
- Reset asserted mid-operation clears all state asynchronously. After deassertion the block re-primes; the first settled value produces no event.
- `out_valid` never drops without a transfer, except on `clear` or reset.

## Structure
- Shared package `ripple_pkg`:
  - FSM state typedef (`PRIME`, `TRACK`).
  - Default constants `RIPPLE_CNT_W`=4 and `RIPPLE_STABLE_CYCLES`=2, also usable by the ripple counter.
- One natural sub-module, `ripple_sync_filter`: synchroniser plus stability counter, outputting `settled` and `value`.
- Delta arithmetic, FSM and output register stay in `ripple_sampler`.

## Test plan
1. Reset released, `ripple_q`=5 held → no `out_valid` ever; state TRACK, `last`=5.
2. Primed at 5, then `ripple_q`=9 held → `out_valid` at edge 4 after the change, `out_delta`=4, `out_total`=4.
3. Primed at 14, then `ripple_q`=2 → `out_delta`=4 (wrap mod 16), `out_total`=4.
4. `ripple_q` glitches to 7 for 1 cycle between steady values 3 and 4 → single event `out_delta`=1; 7 is never accepted.
5. `out_ready`=0, steps 3→5→6 → `out_valid` held, `out_delta`=3; then `out_ready`=1 with step 6→8 in the same cycle → transfer of 3, next `out_delta`=2.
6. `out_total` preloaded by events to 65535, step +1 → `out_total`=0, `overflow`=1. `clear` → all outputs 0, state PRIME. Reset low mid-stream → all outputs 0 immediately.
